// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between two requesters. Port 0 is the core's
// fetch/load/store path and port 1 is the loader or debug/DMA master. Each
// transaction is a full read or write with a req/ack handshake, and the
// arbiter waits out a fixed memory read latency before acknowledging.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   pN_req/we/addr/wdata   requester N transaction request (N = 0, 1)
//   pN_ack            one-cycle transaction-complete pulse
//   pN_rdata          registered read data for requester N
//   mem_addr/wdata/we registered memory port outputs (we is a 1-cycle strobe)
//   mem_rdata         memory read data, valid MEM_LATENCY cycles after addr
//   busy              high while a transaction is in ACCESS or RESPOND
//   grant_id          port owning the current or most recent transaction
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MEM_LATENCY    = 1,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_id
);

    // Counter preload: lat_cnt counts down to zero, so the load value is one
    // less than the latency.
    localparam logic [3:0] LAT_INIT = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t     state_r;
    logic [3:0] lat_cnt_r;
    logic       last_grant_r;
    // mem_we is only a one-cycle strobe, so the direction of the transaction
    // in flight is kept separately for the end-of-access decision.
    logic       txn_we_r;

    logic       any_req_s;
    logic       pick_p1_s;

    // Winner selection for the next IDLE edge.
    always_comb begin
        any_req_s = p0_req | p1_req;
        pick_p1_s = 1'b0;
        if (p0_req && p1_req) begin
            if (FIXED_PRIORITY != 0) begin
                pick_p1_s = 1'b0;
            end else begin
                // Round-robin: hand the tie to whoever did not go last.
                pick_p1_s = ~last_grant_r;
            end
        end else begin
            pick_p1_s = p1_req;
        end
    end

    // Transaction sequencer with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            lat_cnt_r    <= 4'd0;
            last_grant_r <= 1'b1;
            txn_we_r     <= 1'b0;
            p0_ack       <= 1'b0;
            p1_ack       <= 1'b0;
            p0_rdata     <= '0;
            p1_rdata     <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_we       <= 1'b0;
            busy         <= 1'b0;
            grant_id     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        mem_addr     <= pick_p1_s ? p1_addr  : p0_addr;
                        mem_wdata    <= pick_p1_s ? p1_wdata : p0_wdata;
                        mem_we       <= pick_p1_s ? p1_we    : p0_we;
                        txn_we_r     <= pick_p1_s ? p1_we    : p0_we;
                        grant_id     <= pick_p1_s;
                        last_grant_r <= pick_p1_s;
                        lat_cnt_r    <= LAT_INIT;
                        busy         <= 1'b1;
                        state_r      <= ACCESS;
                    end else begin
                        mem_we <= 1'b0;
                    end
                end
                ACCESS: begin
                    mem_we <= 1'b0;
                    if (lat_cnt_r != 4'd0) begin
                        lat_cnt_r <= lat_cnt_r - 4'd1;
                    end else begin
                        if (!txn_we_r) begin
                            if (grant_id) begin
                                p1_rdata <= mem_rdata;
                            end else begin
                                p0_rdata <= mem_rdata;
                            end
                        end
                        p0_ack  <= ~grant_id;
                        p1_ack  <= grant_id;
                        state_r <= RESPOND;
                    end
                end
                RESPOND: begin
                    p0_ack  <= 1'b0;
                    p1_ack  <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    p0_ack  <= 1'b0;
                    p1_ack  <= 1'b0;
                    mem_we  <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Two arbiter instances share one set of requester/memory inputs:
//   rr_*  round-robin, MEM_LATENCY = 1
//   fp_*  fixed priority, MEM_LATENCY = 3
// A cycle table drives the round-robin instance through single reads/writes
// and contention; hand sequences cover latency 3, starvation, alternation
// and reset in the middle of a write.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata, mem_rdata;

    logic        rr_p0_ack, rr_p1_ack, rr_mem_we, rr_busy, rr_grant;
    logic [31:0] rr_p0_rdata, rr_p1_rdata, rr_mem_addr, rr_mem_wdata;
    logic        fp_p0_ack, fp_p1_ack, fp_mem_we, fp_busy, fp_grant;
    logic [31:0] fp_p0_rdata, fp_p1_rdata, fp_mem_addr, fp_mem_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .FIXED_PRIORITY(0)) dut_rr (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(rr_p0_ack), .p0_rdata(rr_p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(rr_p1_ack), .p1_rdata(rr_p1_rdata),
        .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata), .mem_we(rr_mem_we),
        .mem_rdata(mem_rdata), .busy(rr_busy), .grant_id(rr_grant)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .FIXED_PRIORITY(1)) dut_fp (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(fp_p0_ack), .p0_rdata(fp_p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(fp_p1_ack), .p1_rdata(fp_p1_rdata),
        .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_we(fp_mem_we),
        .mem_rdata(mem_rdata), .busy(fp_busy), .grant_id(fp_grant)
    );

    typedef struct {
        logic        rst;
        logic        req0;
        logic        we0;
        logic [31:0] addr0;
        logic [31:0] wdata0;
        logic        req1;
        logic        we1;
        logic [31:0] addr1;
        logic [31:0] wdata1;
        logic [31:0] mrdata;
        logic        e_ack0;
        logic        e_ack1;
        logic [31:0] e_rdata0;
        logic [31:0] e_rdata1;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
        logic        e_mwe;
        logic        e_busy;
        logic        e_grant;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0;
        mem_rdata = 32'h0;
        step();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int rr_cnt;
        int fp0_cnt;
        int fp1_cnt;
        int last_k;
        int found;
        logic exp_port;

        rst = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0;
        mem_rdata = 32'h0;

        //            rst   req0  we0   addr0          wdata0        req1  we1   addr1          wdata1        mrdata         ack0  ack1  rdata0         rdata1         maddr          mwdata         mwe   busy  grant
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0513, 1'b1, 1'b0, 32'h0000_0513, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0513, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0513, 32'h0000_0000, 32'h8000_0010, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_0513, 32'h0000_0000, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0513, 32'h0000_0000, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0513, 32'h0000_0000, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_00AA, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_00BB, 32'h1111_0000, 1'b0, 1'b0, 32'h0000_0513, 32'h0000_0000, 32'h0000_0100, 32'h0000_00AA, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_00AA, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_00BB, 32'h1111_0000, 1'b1, 1'b0, 32'h1111_0000, 32'h0000_0000, 32'h0000_0100, 32'h0000_00AA, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_00AA, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_00BB, 32'h2222_0000, 1'b0, 1'b0, 32'h1111_0000, 32'h0000_0000, 32'h0000_0100, 32'h0000_00AA, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_00AA, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_00BB, 32'h2222_0000, 1'b0, 1'b0, 32'h1111_0000, 32'h0000_0000, 32'h0000_0200, 32'h0000_00BB, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_00AA, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_00BB, 32'h2222_0000, 1'b0, 1'b1, 32'h1111_0000, 32'h2222_0000, 32'h0000_0200, 32'h0000_00BB, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_00AA, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_00BB, 32'h2222_0000, 1'b0, 1'b0, 32'h1111_0000, 32'h2222_0000, 32'h0000_0200, 32'h0000_00BB, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_00AA, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_00BB, 32'h2222_0000, 1'b0, 1'b0, 32'h1111_0000, 32'h2222_0000, 32'h0000_0100, 32'h0000_00AA, 1'b0, 1'b1, 1'b0};

        // Table: inputs applied on the falling edge, outputs checked after the rising edge.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            p0_req = vecs[i].req0; p0_we = vecs[i].we0; p0_addr = vecs[i].addr0; p0_wdata = vecs[i].wdata0;
            p1_req = vecs[i].req1; p1_we = vecs[i].we1; p1_addr = vecs[i].addr1; p1_wdata = vecs[i].wdata1;
            mem_rdata = vecs[i].mrdata;
            step();
            chk($sformatf("v%0d p0_ack", i),    {31'd0, rr_p0_ack},  {31'd0, vecs[i].e_ack0});
            chk($sformatf("v%0d p1_ack", i),    {31'd0, rr_p1_ack},  {31'd0, vecs[i].e_ack1});
            chk($sformatf("v%0d p0_rdata", i),  rr_p0_rdata,         vecs[i].e_rdata0);
            chk($sformatf("v%0d p1_rdata", i),  rr_p1_rdata,         vecs[i].e_rdata1);
            chk($sformatf("v%0d mem_addr", i),  rr_mem_addr,         vecs[i].e_maddr);
            chk($sformatf("v%0d mem_wdata", i), rr_mem_wdata,        vecs[i].e_mwdata);
            chk($sformatf("v%0d mem_we", i),    {31'd0, rr_mem_we},  {31'd0, vecs[i].e_mwe});
            chk($sformatf("v%0d busy", i),      {31'd0, rr_busy},    {31'd0, vecs[i].e_busy});
            chk($sformatf("v%0d grant_id", i),  {31'd0, rr_grant},   {31'd0, vecs[i].e_grant});
        end

        // Latency-3 read on the fixed-priority instance; data is garbage until the capture edge.
        do_reset();
        chk("fp_reset_grant", {31'd0, fp_grant}, 32'd0);
        chk("fp_reset_busy",  {31'd0, fp_busy},  32'd0);
        chk("fp_reset_maddr", fp_mem_addr,       32'd0);
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h0000_0040;
        mem_rdata = 32'hBAD0_BAD0;
        step();
        chk("lat3_maddr", fp_mem_addr, 32'h0000_0040);
        chk("lat3_busy",  {31'd0, fp_busy}, 32'd1);
        step();
        chk("lat3_ack_e1", {31'd0, fp_p0_ack}, 32'd0);
        step();
        chk("lat3_ack_e2", {31'd0, fp_p0_ack}, 32'd0);
        @(negedge clk);
        mem_rdata = 32'h1234_5678;
        step();
        chk("lat3_ack_e3",   {31'd0, fp_p0_ack}, 32'd1);
        chk("lat3_rdata_e3", fp_p0_rdata,        32'h1234_5678);
        @(negedge clk);
        mem_rdata = 32'hBAD0_BAD0;
        step();
        chk("lat3_ack_e4",   {31'd0, fp_p0_ack}, 32'd0);
        chk("lat3_rdata_e4", fp_p0_rdata,        32'h1234_5678);
        chk("lat3_busy_e4",  {31'd0, fp_busy},   32'd0);

        // Both requesters held: round-robin alternates every 3 cycles,
        // fixed priority serves only port 0 every 5 cycles.
        do_reset();
        p0_req = 1'b1; p0_addr = 32'h0000_1000;
        p1_req = 1'b1; p1_addr = 32'h0000_2000;
        mem_rdata = 32'h0000_0077;
        rr_cnt = 0; fp0_cnt = 0; fp1_cnt = 0; last_k = -1; exp_port = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (rr_p0_ack || rr_p1_ack) begin
                rr_cnt = rr_cnt + 1;
                chk("rr_single_ack", {31'd0, rr_p0_ack & rr_p1_ack}, 32'd0);
                chk("rr_order", {31'd0, rr_p1_ack}, {31'd0, exp_port});
                chk("rr_gap", k - last_k, 32'd3);
                exp_port = ~exp_port;
                last_k = k;
            end
            if (fp_p0_ack) fp0_cnt = fp0_cnt + 1;
            if (fp_p1_ack) fp1_cnt = fp1_cnt + 1;
        end
        chk("rr_ack_count",  rr_cnt,  32'd13);
        chk("fp_p0_count",   fp0_cnt, 32'd8);
        chk("fp_p1_starved", fp1_cnt, 32'd0);

        // Port 0 drops right after its ack cycle ended; port 1 is served next.
        @(negedge clk);
        p0_req = 1'b0;
        found = 0;
        for (int k = 0; k < 12 && found == 0; k++) begin
            step();
            if (fp_p1_ack) found = 1;
        end
        chk("fp_p1_served", found, 32'd1);
        chk("fp_p1_rdata",  fp_p1_rdata, 32'h0000_0077);

        // Reset in the first ACCESS cycle of a write aborts it without an ack.
        do_reset();
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h0000_0300; p1_wdata = 32'h0000_0055;
        step();
        chk("rst_mid_we_before",  {31'd0, rr_mem_we}, 32'd1);
        chk("rst_mid_grant_pre",  {31'd0, rr_grant},  32'd1);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("rst_mid_we_after",   {31'd0, rr_mem_we}, 32'd0);
        chk("rst_mid_ack1",       {31'd0, rr_p1_ack}, 32'd0);
        chk("rst_mid_busy",       {31'd0, rr_busy},   32'd0);
        chk("rst_mid_grant",      {31'd0, rr_grant},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h0000_0400;
        p1_we = 1'b0;
        step();
        chk("rst_tie_grant", {31'd0, rr_grant}, 32'd0);
        chk("rst_tie_busy",  {31'd0, rr_busy},  32'd1);
        chk("rst_tie_maddr", rr_mem_addr,       32'h0000_0400);
        step();
        chk("rst_tie_ack0",  {31'd0, rr_p0_ack}, 32'd1);
        chk("rst_tie_ack1",  {31'd0, rr_p1_ack}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
